du_scheduler: RTL and testbench
===============================

// Module: du_scheduler
// PURPOSE
//  Shares one pipelined GELU Division Unit (DU) between N_REQ requester lanes.
//  - Round-robin arbitration: at most one issue per cycle into the DU.
//  - Tag shift register tracks which lane owns each in-flight operation.
//  - Routes each DU result back to its lane as a one-hot response.
//  - Provides a drain/flush sequence so the GELU top can quiesce the DU.
// PARAMETERS
//  N_REQ   4   number of requester lanes (>=2)
//  W       32  data width (Q5.26 operands)
//  DU_LAT  5   DU latency, du_valid_in -> du_valid_out, in cycles
//  ID_W    $clog2(N_REQ)  lane-id width (derived)
// PORTS
//  clk            in   1        clock; single clock domain
//  rst            in   1        synchronous, active-high reset
//  req_valid      in   N_REQ    lane i has an operand pair
//  req_ready      out  N_REQ    lane i accepted this cycle (one-hot or zero)
//  req_F          in   N_REQ*W  numerators; lane i at [i*W +: W]
//  req_s_xi       in   N_REQ*W  denominator terms; lane i at [i*W +: W]
//  du_valid_in    out  1        to DU
//  du_F           out  W        to DU
//  du_s_xi        out  W        to DU
//  du_valid_out   in   1        from DU
//  du_exponent    in   W        from DU
//  du_result_sign in   1        from DU
//  rsp_valid      out  N_REQ    one-hot response strobe
//  rsp_exponent   out  W        shared response data
//  rsp_sign       out  1        shared response sign
//  flush_req      in   1        level; stop issuing and drain
//  flush_done     out  1        one-cycle pulse when drained
//  busy           out  1        in-flight != 0 or response pending
//  err_tag        out  1        sticky: DU result with no matching tag, or tag with no result
//  stat_clr       in   1        clear statistics (used only with DU_SCHED_STATS_EN)
//  stat_grants    out  N_REQ*16 per-lane grant counts (used only with DU_SCHED_STATS_EN)
// BEHAVIOUR
//  Reset values
//   - All outputs 0; RR pointer = 0; tag pipe cleared; in-flight = 0; FSM = RUN.
//   - DU reset must be tied to the same reset (DU rst_n = ~rst).
//  Handshake
//   - req_ready[i] = grant[i] & (state==RUN) & ~flush_req.
//   - Transfer occurs when req_valid[i] & req_ready[i]; it is combinational on req_valid.
//   - Lanes hold req_valid and data stable until accepted.
//  Arbitration
//   - Grant goes to the first lane with valid, searching from rr_ptr upward, wrapping N_REQ-1 -> 0.
//   - After a grant to lane i, rr_ptr <= (i+1) mod N_REQ.
//   - With no grant, rr_ptr holds.
//  Issue
//   - du_valid_in, du_F and du_s_xi are registered one cycle after the transfer.
//   - With no transfer, du_valid_in = 0 and the data registers hold.
//  Tags
//   - DU_LAT-deep shift register of {v, id}, aligned with du_valid_in.
//   - The tail tag is compared against du_valid_out every cycle.
//   - Tail v != du_valid_out sets err_tag; it stays set until rst, and any orphan result is dropped.
//  Response
//   - Registered: rsp_valid[tail.id] = 1 with exponent/sign, 1 cycle after du_valid_out.
//   - Total latency from handshake to rsp_valid = DU_LAT + 2 (7 at default).
//   - No backpressure; lanes must sink every response strobe.
//  In-flight counter
//   - Width $clog2(DU_LAT+3).
//   - +1 on issue, -1 on response; both in the same cycle = no change.
//  FSM (enum)
//   - RUN -> DRAIN when flush_req = 1.
//   - DRAIN: no grants; -> DONE when in-flight == 0 and no response pending.
//   - DONE: flush_done = 1 for one cycle; -> RUN if flush_req = 0, else stay DRAIN-idle (no re-pulse) until flush_req falls.
//   - busy = (in-flight != 0) | (rsp_valid != 0).
//  Boundary conditions
//   - Every cycle may issue (full DU throughput).
//   - A single active lane gets back-to-back grants.
//   - flush_req while empty: DONE on the next cycle.
//   - rst mid-operation: all state is discarded with no responses; the DU is reset in the same cycle.
// CONFIGURATION
//  Macro DU_SCHED_STATS_EN
//   - Defined: per-lane 16-bit saturating grant counters on stat_grants.
//     Cleared by rst or stat_clr; stat_clr wins over a same-cycle increment.
//   - Undefined: no counters; stat_grants tied to 0 and stat_clr ignored.
// STRUCTURE
//  - Package du_sched_pkg: DU_LAT default, tag_t struct {v, id}, sched_state_e {RUN, DRAIN, DONE}.
//  - Sub-module rr_arbiter #(N): req, ptr -> one-hot grant; purely combinational.
//  - Tag pipe, counter, FSM and stats live in du_scheduler.
// TESTING (bench instantiates the real DU, DU_LAT=5)
//  1. Lane 2 only, F=0x04000000, s_xi=0 -> rsp_valid=4'b0100 at cycle +7, exponent = DU model result.
//  2. All 4 lanes valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; one result per cycle to the matching lane.
//  3. Lanes 1 and 3 valid with rr_ptr=2 -> lane 3 first, then lane 1; rr_ptr ends at 2.
//  4. 3 issues, then flush_req=1 -> req_ready=0 at once; flush_done pulses the cycle after the 3rd rsp; busy=0.
//  5. Force du_valid_out=1 with an empty tag pipe -> err_tag=1 and sticky, no rsp_valid.
//  6. rst asserted with 4 in flight -> no rsp_valid afterwards, busy=0, and with STATS_EN stat_grants=0.

Source files
------------

// File: rtl/du_sched_pkg.sv
// du_sched_pkg: shared types and defaults for the GELU Division Unit scheduler.
package du_sched_pkg;

  // Default pipeline depth of the shared Division Unit.
  localparam int DU_LAT_DEF = 5;

  // Tag id field is sized for up to 256 lanes; unused upper bits stay zero.
  localparam int TAG_ID_W = 8;

  // One in-flight operation: valid flag plus owning lane.
  typedef struct packed {
    logic                v;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  // Flush sequencing states.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/du_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker. Grants the first requesting
// index found searching upward from ptr and wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [PW-1:0] idx_s;
  logic          found_s;

  // Walk lanes from ptr upward; the first requester takes the one-hot grant.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s        = PW'((int'(ptr) + k) % N);
      grant[idx_s] = grant[idx_s] | (req[idx_s] & ~found_s);
      found_s      = found_s | req[idx_s];
    end
  end

endmodule

// File: rtl/du_scheduler.sv
// du_scheduler: shares one pipelined GELU Division Unit between N_REQ lanes.
// Round-robin issue, tag pipe for result routing, one-hot responses and a
// flush/drain sequence. Optional per-lane grant statistics are compiled in
// with the macro DU_SCHED_STATS_EN; without it stat_grants reads zero.
module du_scheduler
  import du_sched_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int W      = 32,
  parameter int DU_LAT = DU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ*W-1:0] req_F,
  input  logic [N_REQ*W-1:0] req_s_xi,
  output logic               du_valid_in,
  output logic [W-1:0]       du_F,
  output logic [W-1:0]       du_s_xi,
  input  logic               du_valid_out,
  input  logic [W-1:0]       du_exponent,
  input  logic               du_result_sign,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_exponent,
  output logic               rsp_sign,
  input  logic               flush_req,
  output logic               flush_done,
  output logic               busy,
  output logic               err_tag,
  input  logic               stat_clr,
  output logic [N_REQ*16-1:0] stat_grants
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(DU_LAT + 3);

  sched_state_e      state_r, state_s;
  logic              parked_r, parked_s;
  logic [ID_W-1:0]   rr_ptr_r;
  logic [ID_W-1:0]   gnt_id_s;
  logic [ID_W-1:0]   issue_id_r;
  logic [N_REQ-1:0]  grant_s;
  logic [N_REQ-1:0]  tail_onehot_s;
  logic              xfer_s;
  logic              rsp_any_s;
  tag_t              tag_pipe_r [DU_LAT];
  tag_t              tail_s;
  logic [CNT_W-1:0]  inflight_r, inflight_s;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Grants are only exposed while running and not asked to flush.
  always_comb begin
    if ((state_r == RUN) && !flush_req) begin
      req_ready = grant_s;
    end else begin
      req_ready = '0;
    end
  end

  assign xfer_s     = |(req_valid & req_ready);
  assign rsp_any_s  = |rsp_valid;
  assign tail_s     = tag_pipe_r[DU_LAT-1];
  assign busy       = (inflight_r != '0) | rsp_any_s;
  assign flush_done = (state_r == DONE);

  // Encode the one-hot grant into a lane id and the tail tag into a one-hot strobe.
  always_comb begin
    gnt_id_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      gnt_id_s = gnt_id_s | (grant_s[i] ? ID_W'(i) : '0);
    end
    tail_onehot_s = {{(N_REQ-1){1'b0}}, 1'b1} << tail_s.id;
  end

  // In-flight count spans handshake up to the response strobe.
  always_comb begin
    case ({xfer_s, rsp_any_s})
      2'b10:   inflight_s = inflight_r + CNT_W'(1);
      2'b01:   inflight_s = inflight_r - CNT_W'(1);
      default: inflight_s = inflight_r;
    endcase
  end

  // Flush sequencing: drain completes as soon as nothing will be outstanding next cycle.
  always_comb begin
    state_s  = state_r;
    parked_s = parked_r;
    case (state_r)
      RUN: begin
        if (flush_req) begin
          state_s = (inflight_s == '0) ? DONE : DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (parked_r) begin
          if (!flush_req) begin
            state_s  = RUN;
            parked_s = 1'b0;
          end else begin
            state_s = DRAIN;
          end
        end else if (inflight_s == '0) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      DONE: begin
        if (flush_req) begin
          state_s  = DRAIN;
          parked_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s  = RUN;
        parked_s = 1'b0;
      end
    endcase
  end

  // Issue registers, tag pipe, response routing, counters and FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= RUN;
      parked_r     <= 1'b0;
      rr_ptr_r     <= '0;
      issue_id_r   <= '0;
      du_valid_in  <= 1'b0;
      du_F         <= '0;
      du_s_xi      <= '0;
      rsp_valid    <= '0;
      rsp_exponent <= '0;
      rsp_sign     <= 1'b0;
      err_tag      <= 1'b0;
      inflight_r   <= '0;
      for (int k = 0; k < DU_LAT; k++) begin
        tag_pipe_r[k] <= '0;
      end
    end else begin
      state_r     <= state_s;
      parked_r    <= parked_s;
      inflight_r  <= inflight_s;
      du_valid_in <= xfer_s;
      if (xfer_s) begin
        du_F       <= req_F[int'(gnt_id_s)*W +: W];
        du_s_xi    <= req_s_xi[int'(gnt_id_s)*W +: W];
        issue_id_r <= gnt_id_s;
        rr_ptr_r   <= ID_W'((int'(gnt_id_s) + 1) % N_REQ);
      end
      tag_pipe_r[0] <= '{v: du_valid_in, id: TAG_ID_W'(issue_id_r)};
      for (int k = 1; k < DU_LAT; k++) begin
        tag_pipe_r[k] <= tag_pipe_r[k-1];
      end
      // Only a result matched by a live tag is delivered; orphans are dropped.
      if (tail_s.v && du_valid_out) begin
        rsp_valid    <= tail_onehot_s;
        rsp_exponent <= du_exponent;
        rsp_sign     <= du_result_sign;
      end else begin
        rsp_valid <= '0;
      end
      if (tail_s.v != du_valid_out) begin
        err_tag <= 1'b1;
      end
    end
  end

`ifdef DU_SCHED_STATS_EN
  logic [15:0] stat_cnt_r [N_REQ];

  // Per-lane saturating grant counters; clear beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < N_REQ; i++) begin
        stat_cnt_r[i] <= 16'd0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i] && (stat_cnt_r[i] != 16'hFFFF)) begin
          stat_cnt_r[i] <= stat_cnt_r[i] + 16'd1;
        end
      end
    end
  end

  // Pack counters onto the flat statistics bus.
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) begin
      stat_grants[i*16 +: 16] = stat_cnt_r[i];
    end
  end
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_grants     = '0;
`endif

endmodule

// File: tb/tb_du_scheduler.sv
// tb_du_scheduler: randomized and directed bench for du_scheduler with a
// behavioural DU (5-cycle pipe) and a transaction-level reference model.
module tb_du_scheduler;

  localparam int N = 4;
  localparam int W = 32;
  localparam int LAT = 5;
  localparam int RLAT = LAT + 2;

  typedef enum int {M_RUN, M_DRAIN, M_DONE, M_PARK} mode_e;
  typedef struct {
    int           lane;
    logic [W-1:0] f;
    logic [W-1:0] s;
    int           issue;
    int           due;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready, rsp_valid;
  logic [N*W-1:0] req_F, req_s_xi;
  logic du_valid_in, du_valid_out, du_result_sign, rsp_sign;
  logic [W-1:0] du_F, du_s_xi, du_exponent, rsp_exponent;
  logic flush_req, flush_done, busy, err_tag, stat_clr;
  logic [N*16-1:0] stat_grants;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  du_scheduler #(.N_REQ(N), .W(W), .DU_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_F(req_F), .req_s_xi(req_s_xi), .du_valid_in(du_valid_in),
    .du_F(du_F), .du_s_xi(du_s_xi), .du_valid_out(du_valid_out),
    .du_exponent(du_exponent), .du_result_sign(du_result_sign),
    .rsp_valid(rsp_valid), .rsp_exponent(rsp_exponent), .rsp_sign(rsp_sign),
    .flush_req(flush_req), .flush_done(flush_done), .busy(busy),
    .err_tag(err_tag), .stat_clr(stat_clr), .stat_grants(stat_grants)
  );

  // Behavioural Division Unit: arbitrary arithmetic, fixed latency.
  function automatic logic [W-1:0] fn_exp(input logic [W-1:0] f, input logic [W-1:0] s);
    return (f >> 1) ^ s;
  endfunction
  function automatic logic fn_sign(input logic [W-1:0] f, input logic [W-1:0] s);
    return f[W-1] ^ s[W-1];
  endfunction

  logic [LAT-1:0] dp_v;
  logic [W-1:0]   dp_f [LAT];
  logic [W-1:0]   dp_s [LAT];
  logic           force_dvo;

  // DU pipeline, reset together with the scheduler.
  always @(posedge clk) begin
    if (rst) begin
      dp_v <= '0;
    end else begin
      dp_v    <= {dp_v[LAT-2:0], du_valid_in};
      dp_f[0] <= du_F;
      dp_s[0] <= du_s_xi;
      for (int k = 1; k < LAT; k++) begin
        dp_f[k] <= dp_f[k-1];
        dp_s[k] <= dp_s[k-1];
      end
    end
  end
  assign du_valid_out   = dp_v[LAT-1] | force_dvo;
  assign du_exponent    = fn_exp(dp_f[LAT-1], dp_s[LAT-1]);
  assign du_result_sign = fn_sign(dp_f[LAT-1], dp_s[LAT-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s @cycle %0d: bound expired", name, cyc);
  endtask

  function automatic int lane_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference model state and observation logs.
  ent_t  q[$];
  int    m_ptr;
  mode_e m_mode;
  logic  m_err;
  int    m_cnt [N];
  int    g_cyc[$], g_lane[$], r_cyc[$], r_lane[$], d_cyc[$];
  logic [W-1:0] r_exp[$];
  logic d_busy[$];
  logic [N-1:0] acc_mask = '0;

  // Every-cycle comparison of the DUT against the transaction model.
  always @(negedge clk) begin : cmp
    logic [N-1:0] exp_ready, exp_rsp;
    logic [W-1:0] ee;
    logic es, eb, edv;
    logic [W-1:0] edf, eds;
    logic [N*16-1:0] est;
    int g, outn, l;
    if (rst) begin
      q.delete();
      m_ptr = 0; m_mode = M_RUN; m_err = 1'b0; acc_mask = '0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      exp_ready = '0; g = -1;
      if (m_mode == M_RUN && !flush_req) begin
        for (int k = 0; k < N; k++) begin
          l = (m_ptr + k) % N;
          if (g < 0 && req_valid[l]) begin g = l; exp_ready[l] = 1'b1; end
        end
      end
      chk("req_ready", req_ready, exp_ready);
      exp_rsp = '0; ee = '0; es = 1'b0; eb = 1'b0; edv = 1'b0; edf = '0; eds = '0;
      foreach (q[j]) begin
        if (q[j].due == cyc) begin
          exp_rsp[q[j].lane] = 1'b1; ee = fn_exp(q[j].f, q[j].s); es = fn_sign(q[j].f, q[j].s);
        end
        if (q[j].issue < cyc && cyc <= q[j].due) eb = 1'b1;
        if (q[j].issue == cyc - 1) begin edv = 1'b1; edf = q[j].f; eds = q[j].s; end
      end
      chk("rsp_valid", rsp_valid, exp_rsp);
      if (exp_rsp != '0) begin
        chk("rsp_exponent", rsp_exponent, ee);
        chk("rsp_sign", rsp_sign, es);
      end
      chk("du_valid_in", du_valid_in, edv);
      if (edv) begin
        chk("du_F", du_F, edf);
        chk("du_s_xi", du_s_xi, eds);
      end
      chk("busy", busy, eb);
      chk("flush_done", flush_done, m_mode == M_DONE);
      chk("err_tag", err_tag, m_err);
      est = '0;
`ifdef DU_SCHED_STATS_EN
      for (int i = 0; i < N; i++) est[i*16 +: 16] = 16'(m_cnt[i]);
`endif
      chk("stat_grants", stat_grants, est);
      // logs of what the DUT actually did
      acc_mask = req_ready & req_valid;
      if (acc_mask != '0) begin g_cyc.push_back(cyc); g_lane.push_back(lane_of(acc_mask)); end
      if (rsp_valid != '0) begin
        r_cyc.push_back(cyc); r_lane.push_back(lane_of(rsp_valid)); r_exp.push_back(rsp_exponent);
      end
      if (flush_done) begin d_cyc.push_back(cyc); d_busy.push_back(busy); end
      // advance the model
      if (force_dvo) m_err = 1'b1;
      if (g >= 0) begin
        q.push_back('{lane: g, f: req_F[g*W +: W], s: req_s_xi[g*W +: W], issue: cyc, due: cyc + RLAT});
        m_ptr = (g + 1) % N;
      end
      if (stat_clr) begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
      end else if (g >= 0 && m_cnt[g] < 65535) begin
        m_cnt[g]++;
      end
      for (int j = q.size() - 1; j >= 0; j--) if (q[j].due <= cyc) q.delete(j);
      outn = 0;
      foreach (q[j]) if (q[j].issue <= cyc && q[j].due >= cyc + 1) outn++;
      case (m_mode)
        M_RUN:   if (flush_req) m_mode = (outn == 0) ? M_DONE : M_DRAIN;
        M_DRAIN: if (outn == 0) m_mode = M_DONE;
        M_DONE:  m_mode = flush_req ? M_PARK : M_RUN;
        M_PARK:  if (!flush_req) m_mode = M_RUN;
        default: m_mode = M_RUN;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc_mask[i]) req_valid[i] = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic [W-1:0] f, input logic [W-1:0] s);
    req_valid[i] = 1'b1;
    req_F[i*W +: W] = f;
    req_s_xi[i*W +: W] = s;
  endtask

  task automatic clear_logs();
    g_cyc.delete(); g_lane.delete(); r_cyc.delete(); r_lane.delete(); r_exp.delete();
    d_cyc.delete(); d_busy.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_valid != '0 || q.size() != 0) && n < 200) begin step(); n++; end
    if (n >= 200) fail_now(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog @cycle %0d: simulation did not finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f_cyc;
    rst = 1'b1; req_valid = '0; req_F = '0; req_s_xi = '0;
    flush_req = 1'b0; stat_clr = 1'b0; force_dvo = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_du_valid_in", du_valid_in, 0);

    // 1: single lane 2, latency and routing
    clear_logs();
    set_lane(2, 32'h0400_0000, 32'h0);
    for (int n = 0; n < 20 && r_cyc.size() == 0; n++) step();
    if (r_cyc.size() == 0 || g_cyc.size() == 0) fail_now("t1_rsp");
    else begin
      chk("t1_grant_lane", g_lane[0], 2);
      chk("t1_rsp_lane", r_lane[0], 2);
      chk("t1_latency", r_cyc[0] - g_cyc[0], 7);
      chk("t1_exponent", r_exp[0], 64'h0200_0000);
    end
    set_lane(3, 32'h1234_5678, 32'h0000_0001);   // moves the pointer back to 0
    wait_idle("t1_idle");

    // 2: all lanes valid for 8 cycles
    clear_logs();
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N; i++) if (!req_valid[i]) set_lane(i, $urandom, $urandom);
      step();
    end
    req_valid = '0;
    wait_idle("t2_idle");
    if (g_cyc.size() != 8 || r_cyc.size() != 8) fail_now("t2_counts");
    else begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_grant_order", g_lane[k], k % 4);
        chk("t2_grant_cycle", g_cyc[k] - g_cyc[0], k);
        chk("t2_rsp_lane", r_lane[k], k % 4);
        chk("t2_rsp_cycle", r_cyc[k] - g_cyc[k], 7);
      end
    end

    // 3: lanes 1 and 3 with pointer at 2
    set_lane(1, $urandom, $urandom);
    step();
    req_valid = '0;
    clear_logs();
    set_lane(1, $urandom, $urandom);
    set_lane(3, $urandom, $urandom);
    step(); step();
    for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom);
    step();
    req_valid = '0;
    if (g_lane.size() != 3) fail_now("t3_counts");
    else begin
      chk("t3_first", g_lane[0], 3);
      chk("t3_second", g_lane[1], 1);
      chk("t3_ptr_at_2", g_lane[2], 2);
    end
    wait_idle("t3_idle");

    // 4: three issues then flush
    clear_logs();
    for (int i = 0; i < 3; i++) set_lane(i, $urandom, $urandom);
    step(); step(); step();
    flush_req = 1'b1;
    set_lane(0, $urandom, $urandom);
    @(negedge clk);
    chk("t4_ready_blocked", req_ready, 0);
    for (int n = 0; n < 30 && d_cyc.size() == 0; n++) step();
    if (d_cyc.size() == 0 || r_cyc.size() != 3) fail_now("t4_done");
    else begin
      chk("t4_done_after_last_rsp", d_cyc[0] - r_cyc[2], 1);
      chk("t4_busy_at_done", d_busy[0], 0);
    end
    repeat (4) step();
    chk("t4_single_pulse", d_cyc.size(), 1);
    flush_req = 1'b0;
    wait_idle("t4_idle");

    // 4b: flush while empty
    clear_logs();
    flush_req = 1'b1;
    f_cyc = cyc;
    repeat (3) step();
    if (d_cyc.size() == 0) fail_now("t4b_done");
    else chk("t4b_done_next_cycle", d_cyc[0] - f_cyc, 1);
    flush_req = 1'b0;
    step();

    // random traffic with flush and stat_clr activity
    for (int n = 0; n < 3000; n++) begin
      int load;
      load = ((n / 500) % 2 == 1) ? 95 : 35;
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 99) < load) set_lane(i, $urandom, $urandom);
      if ($urandom_range(0, 99) < 2) flush_req = ~flush_req;
      stat_clr = ($urandom_range(0, 99) < 1);
      step();
    end
    flush_req = 1'b0;
    stat_clr = 1'b0;
    req_valid = '0;
    wait_idle("rand_idle");
    repeat (3) step();

    // 5: orphan DU result
    clear_logs();
    force_dvo = 1'b1;
    step();
    force_dvo = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("t5_err_sticky", err_tag, 1);
    chk("t5_no_rsp", r_cyc.size(), 0);

    // 6: reset with four in flight
    for (int i = 0; i < N; i++) set_lane(i, $urandom, $urandom);
    repeat (4) step();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
    clear_logs();
    repeat (12) step();
    @(negedge clk);
    chk("t6_no_rsp", r_cyc.size(), 0);
    chk("t6_busy", busy, 0);
    chk("t6_err_cleared", err_tag, 0);
    chk("t6_stats", stat_grants, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
